// File: rtl/biriscv_pc_trace_streamer.sv
// biriscv_pc_trace_streamer
// Producer side of the core PC trace. Each cycle it samples the two issue-slot
// PCs, stamps them with a free-running cycle count and interleaves periodic
// heartbeat records. Records are buffered in a first-word-fall-through FIFO and
// streamed over a valid/ready port. Records that cannot be buffered are counted,
// and the count is reported in-band as an OVERFLOW record once space frees up.
module biriscv_pc_trace_streamer #(
  parameter int CYCLE_W   = 48,
  parameter int DEPTH     = 16,
  parameter int HEARTBEAT = 100000,
  parameter int DROP_W    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    enable_i,
  input  logic                    flush_i,
  input  logic                    pc0_valid_i,
  input  logic [31:0]             pc0_i,
  input  logic                    pc1_valid_i,
  input  logic [31:0]             pc1_i,
  output logic                    rec_valid_o,
  input  logic                    rec_ready_i,
  output logic [68+CYCLE_W-1:0]   rec_data_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    drop_pend_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = 68 + CYCLE_W;
  localparam int HB_W  = (HEARTBEAT > 1) ? $clog2(HEARTBEAT) : 1;

  localparam logic [AW:0]       FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [DROP_W-1:0] DROP_MAX   = '1;

  typedef enum logic [1:0] {
    KIND_TRACE     = 2'b00,
    KIND_HEARTBEAT = 2'b01,
    KIND_OVERFLOW  = 2'b10
  } kind_e;

  logic [CYCLE_W-1:0] cycle;
  logic [HB_W-1:0]    hb_cnt;
  logic               tick;

  logic [REC_W-1:0]   mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        level;

  logic [DROP_W-1:0]  drop;
  logic [DROP_W-1:0]  drop_next;

  logic               cand_valid;
  logic [REC_W-1:0]   cand_rec;
  logic               pop;
  logic               room;
  logic               push;
  logic [REC_W-1:0]   push_rec;

  // Free-running cycle stamp; ignores enable and flush, wraps naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cycle <= '0;
    else         cycle <= cycle + 1'b1;
  end

  // Heartbeat down-counter: a zero count is a tick, so the first tick lands on
  // the first cycle after reset and then every HEARTBEAT cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hb_cnt <= '0;
    end else if (HEARTBEAT != 0) begin
      if (hb_cnt == '0) hb_cnt <= HB_W'(HEARTBEAT - 1);
      else              hb_cnt <= hb_cnt - 1'b1;
    end
  end

  assign tick = (HEARTBEAT != 0) && (hb_cnt == '0);

  // Build this cycle's candidate record; a heartbeat takes priority over a trace.
  always_comb begin
    cand_valid = 1'b0;
    cand_rec   = '0;
    if (enable_i) begin
      if (tick) begin
        cand_valid = 1'b1;
        cand_rec   = {KIND_HEARTBEAT, pc1_valid_i, pc0_valid_i, pc1_i, pc0_i, cycle};
      end else if (pc0_valid_i || pc1_valid_i) begin
        cand_valid = 1'b1;
        cand_rec   = {KIND_TRACE, pc1_valid_i, pc0_valid_i,
                      pc1_valid_i ? pc1_i : 32'h0,
                      pc0_valid_i ? pc0_i : 32'h0,
                      cycle};
      end
    end
  end

  // Decide the single FIFO write for this cycle and the next drop count. A
  // pending drop count always gets reported before new records are accepted.
  always_comb begin
    pop       = rec_valid_o && rec_ready_i && !flush_i;
    room      = (level != FULL_LEVEL) || pop;
    push      = 1'b0;
    push_rec  = cand_rec;
    drop_next = drop;
    if (flush_i) begin
      drop_next = '0;
    end else if ((drop != '0) && room) begin
      push      = 1'b1;
      push_rec  = {KIND_OVERFLOW, 2'b00, 32'h0, 32'(drop), cycle};
      drop_next = cand_valid ? DROP_W'(1) : '0;
    end else if (cand_valid && room) begin
      push = 1'b1;
    end else if (cand_valid) begin
      if (drop != DROP_MAX) drop_next = drop + 1'b1;
    end
  end

  // FIFO pointers and occupancy; flush empties the buffer in one edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy level.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_rec;
  end

  // Saturating count of records lost since the last OVERFLOW report.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) drop <= '0;
    else         drop <= drop_next;
  end

  assign rec_valid_o = (level != '0);
  assign rec_data_o  = rec_valid_o ? mem[rd_ptr] : '0;
  assign level_o     = level;
  assign drop_pend_o = (drop != '0);

endmodule

// File: tb/tb_biriscv_pc_trace_streamer.sv
// Testbench for biriscv_pc_trace_streamer: directed scenarios plus randomized
// traffic, all checked against a queue-based reference model.
module tb_biriscv_pc_trace_streamer;

  localparam int CYCLE_W  = 48;
  localparam int DEPTH    = 16;
  localparam int HB       = 4;
  localparam int DROP_W   = 3;
  localparam int REC_W    = 68 + CYCLE_W;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable, flush, v0, v1, ready;
  logic [31:0]       pc0, pc1;

  logic              rec_valid, drop_pend;
  logic [REC_W-1:0]  rec_data;
  logic [4:0]        level;

  logic              z_valid, z_pend;
  logic [REC_W-1:0]  z_data;
  logic [2:0]        z_level;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [REC_W-1:0] exp_q[$];
  longint unsigned  m_cycle = 0;
  int               m_drop  = 0;

  biriscv_pc_trace_streamer #(
    .CYCLE_W(CYCLE_W), .DEPTH(DEPTH), .HEARTBEAT(HB), .DROP_W(DROP_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .flush_i(flush),
    .pc0_valid_i(v0), .pc0_i(pc0), .pc1_valid_i(v1), .pc1_i(pc1),
    .rec_valid_o(rec_valid), .rec_ready_i(ready), .rec_data_o(rec_data),
    .level_o(level), .drop_pend_o(drop_pend)
  );

  biriscv_pc_trace_streamer #(
    .CYCLE_W(CYCLE_W), .DEPTH(4), .HEARTBEAT(0), .DROP_W(16)
  ) dut_nohb (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .flush_i(flush),
    .pc0_valid_i(v0), .pc0_i(pc0), .pc1_valid_i(v1), .pc1_i(pc1),
    .rec_valid_o(z_valid), .rec_ready_i(ready), .rec_data_o(z_data),
    .level_o(z_level), .drop_pend_o(z_pend)
  );

  // Clock generation
  always #5 clk = ~clk;

  // Behavioural model: one record decision per cycle, FIFO as a queue
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        m_cycle = 0;
        m_drop  = 0;
      end else begin
        bit tick, cand, pop, room;
        logic [REC_W-1:0] rec;
        tick = (HB != 0) && ((m_cycle % HB) == 0);
        cand = enable && (tick || v0 || v1);
        if (tick) rec = {2'b01, v1, v0, pc1, pc0, CYCLE_W'(m_cycle)};
        else      rec = {2'b00, v1, v0, v1 ? pc1 : 32'h0, v0 ? pc0 : 32'h0, CYCLE_W'(m_cycle)};
        if (flush) begin
          exp_q.delete();
          m_drop = 0;
        end else begin
          pop  = (exp_q.size() != 0) && ready;
          room = (exp_q.size() < DEPTH) || pop;
          if (pop) void'(exp_q.pop_front());
          if (m_drop != 0 && room) begin
            exp_q.push_back({2'b10, 2'b00, 32'h0, 32'(m_drop), CYCLE_W'(m_cycle)});
            m_drop = cand ? 1 : 0;
          end else if (cand && room) begin
            exp_q.push_back(rec);
          end else if (cand) begin
            m_drop = (m_drop == DROP_MAX) ? DROP_MAX : m_drop + 1;
          end
        end
        m_cycle++;
      end
    end
  end

  function automatic logic [REC_W-1:0] exp_data();
    return (exp_q.size() != 0) ? exp_q[0] : '0;
  endfunction

  function automatic logic [4:0] exp_level();
    return 5'(exp_q.size());
  endfunction

  task automatic apply_inputs(input logic en, input logic fl, input logic a0,
                              input logic [31:0] p0, input logic a1,
                              input logic [31:0] p1, input logic rdy);
    enable = en; flush = fl; v0 = a0; pc0 = p0; v1 = a1; pc1 = p1; ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Short reset pulse placed between clock edges
  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    apply_inputs(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    #2;
    n_checks++;
    if ({rec_valid, drop_pend, level, rec_data} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: valid=%b pend=%b level=%0d data=%h expected all zero",
               rec_valid, drop_pend, level, rec_data);
    end
    n_checks++;
    if ({z_valid, z_pend, z_level, z_data} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs_nohb: valid=%b level=%0d expected all zero", z_valid, z_level);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_heartbeat();
    int seen = 0;
    apply_inputs(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 24; i++) begin
      step();
      n_checks++;
      if ({rec_valid, drop_pend, level, rec_data} !==
          {exp_q.size() != 0, m_drop != 0, exp_level(), exp_data()}) begin
        n_fail++;
        $display("[TB] FAIL heartbeat_model: valid=%b level=%0d data=%h expected valid=%b level=%0d data=%h",
                 rec_valid, level, rec_data, exp_q.size() != 0, exp_level(), exp_data());
      end
      if (rec_valid === 1'b1) begin
        n_checks++;
        if (rec_data[REC_W-1 -: 2] !== 2'b01 || rec_data[CYCLE_W-1:0] !== CYCLE_W'(seen * HB)) begin
          n_fail++;
          $display("[TB] FAIL heartbeat_stamp: kind=%b stamp=%0d expected kind=01 stamp=%0d",
                   rec_data[REC_W-1 -: 2], rec_data[CYCLE_W-1:0], seen * HB);
        end
        seen++;
      end
    end
    n_checks++;
    if (seen != 6) begin
      n_fail++;
      $display("[TB] FAIL heartbeat_count: got %0d expected 6", seen);
    end
  endtask

  task automatic test_no_heartbeat();
    logic [REC_W-1:0] want;
    want = {2'b00, 1'b0, 1'b1, 32'h0, 32'h80000000, 48'd10};
    pulse_reset();
    apply_inputs(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 20 && m_cycle != 10; i++) step();
    n_checks++;
    if (z_valid !== 1'b0 || m_cycle != 10) begin
      n_fail++;
      $display("[TB] FAIL nohb_idle: valid=%b cycle=%0d expected valid=0 cycle=10", z_valid, m_cycle);
    end
    apply_inputs(1'b1, 1'b0, 1'b1, 32'h80000000, 1'b0, 32'h1234, 1'b1);
    step();
    n_checks++;
    if (z_valid !== 1'b1 || z_data !== want) begin
      n_fail++;
      $display("[TB] FAIL nohb_trace: valid=%b data=%h expected valid=1 data=%h", z_valid, z_data, want);
    end
    apply_inputs(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step();
    n_checks++;
    if (z_valid !== 1'b0 || z_level !== 3'd0) begin
      n_fail++;
      $display("[TB] FAIL nohb_drained: valid=%b level=%0d expected valid=0 level=0", z_valid, z_level);
    end
  endtask

  task automatic test_overflow();
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      apply_inputs(1'b1, 1'b0, 1'b1, $urandom, 1'b0, $urandom, 1'b0);
      step();
    end
    n_checks++;
    if (level !== 5'd16 || drop_pend !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL overflow_fill: level=%0d pend=%b expected level=16 pend=1", level, drop_pend);
    end
    apply_inputs(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    for (int i = 1; i <= 17; i++) begin
      step();
      n_checks++;
      if ({rec_valid, drop_pend, level, rec_data} !==
          {exp_q.size() != 0, m_drop != 0, exp_level(), exp_data()}) begin
        n_fail++;
        $display("[TB] FAIL overflow_model: valid=%b pend=%b level=%0d data=%h expected valid=%b pend=%b level=%0d data=%h",
                 rec_valid, drop_pend, level, rec_data, exp_q.size() != 0, m_drop != 0, exp_level(), exp_data());
      end
      if (i == 1) begin
        n_checks++;
        if (drop_pend !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL overflow_pend_fall: pend=%b expected 0", drop_pend);
        end
      end
      if (i == 16) begin
        n_checks++;
        if (rec_data[REC_W-1 -: 2] !== 2'b10 || rec_data[CYCLE_W +: 32] !== 32'd4) begin
          n_fail++;
          $display("[TB] FAIL overflow_record: kind=%b pc0=%0d expected kind=10 pc0=4",
                   rec_data[REC_W-1 -: 2], rec_data[CYCLE_W +: 32]);
        end
      end
      if (i == 17) begin
        n_checks++;
        if (rec_valid !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL overflow_drained: valid=%b expected 0", rec_valid);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    for (int i = 0; i < 16; i++) begin
      apply_inputs(1'b1, 1'b0, 1'b1, $urandom, 1'b1, $urandom, 1'b0);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      apply_inputs(1'b1, 1'b0, 1'b1, $urandom, 1'b1, $urandom, 1'b1);
      step();
      n_checks++;
      if (level !== 5'd16 || drop_pend !== 1'b0 || rec_data !== exp_data()) begin
        n_fail++;
        $display("[TB] FAIL back_to_back: level=%0d pend=%b data=%h expected level=16 pend=0 data=%h",
                 level, drop_pend, rec_data, exp_data());
      end
    end
  endtask

  task automatic test_tick_and_trace();
    logic [REC_W-1:0] want;
    pulse_reset();
    apply_inputs(1'b1, 1'b0, 1'b1, 32'h0000_1000, 1'b1, 32'h0000_1004, 1'b1);
    step();
    want = {2'b01, 1'b1, 1'b1, 32'h0000_1004, 32'h0000_1000, 48'd0};
    n_checks++;
    if (rec_valid !== 1'b1 || level !== 5'd1 || rec_data !== want) begin
      n_fail++;
      $display("[TB] FAIL tick_and_trace: valid=%b level=%0d data=%h expected valid=1 level=1 data=%h",
               rec_valid, level, rec_data, want);
    end
  endtask

  task automatic test_flush_and_reset();
    pulse_reset();
    for (int i = 0; i < 19; i++) begin
      apply_inputs(1'b1, 1'b0, 1'b1, $urandom, 1'b0, 32'h0, 1'b0);
      step();
    end
    n_checks++;
    if (level !== 5'd16 || drop_pend !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL flush_prefill: level=%0d pend=%b expected level=16 pend=1", level, drop_pend);
    end
    apply_inputs(1'b1, 1'b1, 1'b1, 32'hABCD_0000, 1'b0, 32'h0, 1'b1);
    step();
    n_checks++;
    if ({rec_valid, drop_pend, level, rec_data} !== '0) begin
      n_fail++;
      $display("[TB] FAIL flush_clear: valid=%b pend=%b level=%0d expected all zero", rec_valid, drop_pend, level);
    end
    apply_inputs(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (rec_valid !== 1'b0 || drop_pend !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL flush_no_overflow: valid=%b pend=%b expected 0 0", rec_valid, drop_pend);
      end
    end
    for (int i = 0; i < 5; i++) begin
      apply_inputs(1'b1, 1'b0, 1'b1, $urandom, 1'b0, 32'h0, 1'b0);
      step();
    end
    n_checks++;
    if (level !== 5'd5) begin
      n_fail++;
      $display("[TB] FAIL reset_prefill: level=%0d expected 5", level);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rec_valid, drop_pend, level, rec_data} !== '0) begin
      n_fail++;
      $display("[TB] FAIL async_reset: valid=%b pend=%b level=%0d data=%h expected all zero",
               rec_valid, drop_pend, level, rec_data);
    end
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int rdy_pct = 100;
    pulse_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        case ($urandom_range(3))
          0: rdy_pct = 0;
          1: rdy_pct = 30;
          2: rdy_pct = 70;
          default: rdy_pct = 100;
        endcase
      end
      apply_inputs(($urandom % 16) != 0, ($urandom % 80) == 0,
                   $urandom_range(1), $urandom, $urandom_range(1), $urandom,
                   $urandom_range(99) < rdy_pct);
      step();
      n_checks++;
      if ({rec_valid, drop_pend, level, rec_data} !==
          {exp_q.size() != 0, m_drop != 0, exp_level(), exp_data()}) begin
        n_fail++;
        $display("[TB] FAIL random_model @%0d: valid=%b pend=%b level=%0d data=%h expected valid=%b pend=%b level=%0d data=%h",
                 i, rec_valid, drop_pend, level, rec_data, exp_q.size() != 0, m_drop != 0, exp_level(), exp_data());
      end
    end
  endtask

  initial begin
    test_reset();
    test_heartbeat();
    test_no_heartbeat();
    test_overflow();
    test_back_to_back();
    test_tick_and_trace();
    test_flush_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
